beam_trigger_scaler: RTL and testbench
======================================

# beam_trigger_scaler

Per-beam trigger rate scaler sitting directly downstream of the beam alignment/beamformer stage. It consumes the `trigger_o[NBEAMS-1:0]` vector produced each clock and counts rising edges per beam over a programmable gate period. At each period end it transfers all counts atomically into holding registers. Software reads those counts back through a registered address/data port for threshold servoing.

## Interface
Parameters:
- `NBEAMS`, 2, number of beam trigger bits, matching the beamformer's `NBEAMS`.
- `COUNT_WIDTH`, 16, width of each per-beam count.
- `PERIOD_WIDTH`, 32, width of the gate period value.

Ports:
- `clk_i` input 1: beamformer clock; single clock domain.
- `rst_i` input 1: synchronous, active-high reset.
- `trigger_i` input NBEAMS: per-beam trigger level, straight from the beamformer `trigger_o`.
- `period_i` input PERIOD_WIDTH: gate length in clocks; 0 is treated as 1.
- `rd_addr_i` input ADDR_W: beam index to read. `ADDR_W = max(1, $clog2(NBEAMS))`.
- `rd_data_o` output COUNT_WIDTH+1: `{sat, count}` of the held value, registered.
- `scal_valid_o` output 1: one-cycle pulse when new held values are available.

## Operation
- **Edge detect:** `trig_q[b]` registers `trigger_i[b]`. An event occurs in a cycle where `trigger_i[b]` is 1 and `trig_q[b]` is 0. A level held high for N cycles counts once.
- **Live counter:** each beam has a COUNT_WIDTH live counter that increments by 1 per event. It saturates at 2^COUNT_WIDTH-1 and sets a sticky `sat` bit when an event arrives at saturation. It never wraps.
- **Gate counter:** counts 0 .. `period_q`-1, then wraps to 0.
  - `period_q` is loaded from `period_i` (0 mapped to 1) during reset and in every terminal cycle.
  - A `period_i` change mid-gate therefore takes effect only from the next gate.
- **Terminal cycle** (gate count == `period_q`-1):
  - Holding register `<=` {sat, live count including any event in this same cycle}.
  - Live counter and `sat` `<=` 0.
  - The transfer occurs for all beams in the same cycle.
- **Readout:**
  - `rd_data_o <= hold[rd_addr_i]`; `rd_addr_i >= NBEAMS` returns 0.
  - A read in the same cycle as a transfer returns the pre-transfer held value.
- **Reset:** clears all state. `trig_q`, live counters, `sat`, holding registers, gate counter, `rd_data_o` and `scal_valid_o` are all 0.
  - A trigger level already high when reset deasserts does not count, because `trig_q` has not yet observed a low.
  - Reset asserted mid-gate discards the partial counts and does not pulse `scal_valid_o`.

## Timing
- Event in cycle n: live count is updated at the clock edge ending cycle n.
- Terminal cycle t:
  - holding registers updated at the edge ending t;
  - `scal_valid_o` high during t+1 only;
  - a read issued in t+1 returns the new values in t+2.
- Read latency: 1 clock from `rd_addr_i` to `rd_data_o`, for any address.
- First gate after reset release:
  - the first cycle with `rst_i` low is gate count 0;
  - with `period_i` = P, the first `scal_valid_o` pulse falls P cycles after that cycle.
- `period_q` = 1: every cycle is terminal and `scal_valid_o` stays high continuously.
- Throughput: one event per beam every 2 cycles maximum, inherent in edge counting.

## Structure
- **Package `beam_scaler_pkg`:**
  - default `COUNT_WIDTH` and `PERIOD_WIDTH` constants;
  - a `clog2_min1` function for `ADDR_W`;
  - a packed struct `scal_word_t` of `{sat, count}`.
- **Sub-module `beam_scaler_counter`:** one instance per beam via generate. It contains the edge detect, saturating live counter, sticky `sat` and holding register, with inputs `trig`, `terminal` and output `hold`.
- **Top level:** gate counter, `period_q` latch, `scal_valid_o` register and read mux.

## Test plan
- **Basic count:** NBEAMS=2, `period_i`=100; drive 7 single-cycle pulses on beam 0 and 3 on beam 1 within one gate. Required: `scal_valid_o` pulses once; reading addr 0 gives `{0,7}`, addr 1 gives `{0,3}`.
- **Held level:** hold `trigger_i[0]` high for 50 cycles inside a gate. Required: count 1.
- **Saturation:** COUNT_WIDTH=4, 20 pulses in one gate. Required: `{1,15}`; the next gate with 2 pulses reads `{0,2}`.
- **Terminal-cycle edge:** pulse on beam 1 exactly in the terminal cycle. Required: it is counted in the closing gate. A pulse in the following cycle is counted in the next gate.
- **Period change and period 0:**
  - Change `period_i` 100→10 mid-gate. Required: the current gate still lasts 100 cycles, then pulses occur every 10.
  - `period_i`=0. Required: `scal_valid_o` stays continuously high.
- **Reset and out-of-range read:**
  - Assert `rst_i` mid-gate after 5 pulses. Required: no `scal_valid_o`; the next gate reads only post-reset events.
  - Reading `rd_addr_i`=3 with NBEAMS=2 returns 0.

Source files
------------

// File: rtl/beam_scaler_pkg.sv
// Shared constants, types and helpers for the beam trigger rate scaler.
// Imported by the per-beam counter and by the top level.
package beam_scaler_pkg;

    localparam int COUNT_WIDTH_DEF  = 16;
    localparam int PERIOD_WIDTH_DEF = 32;

    typedef struct packed {
        logic                       sat;
        logic [COUNT_WIDTH_DEF-1:0] count;
    } scal_word_t;

    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/beam_scaler_counter.sv
// One beam: rising-edge detect, saturating live counter with sticky sat,
// and the holding register loaded at the gate terminal cycle.
module beam_scaler_counter
    import beam_scaler_pkg::*;
#(
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trig,
    input  logic                 terminal,
    output logic [COUNT_WIDTH:0] hold
);

    localparam logic [COUNT_WIDTH-1:0] C_ONE = 1;

    logic                   trig_q;
    logic                   seen_low;
    logic                   sat;
    logic                   sat_nxt;
    logic                   evt;
    logic [COUNT_WIDTH-1:0] live;
    logic [COUNT_WIDTH-1:0] live_nxt;

    // A level high across reset release must first be seen low to count.
    assign evt = trig & ~trig_q & seen_low;

    always_comb begin
        live_nxt = live;
        sat_nxt  = sat;
        if (evt) begin
            if (&live) begin
                sat_nxt = 1'b1;
            end else begin
                live_nxt = live + C_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q   <= 1'b0;
            seen_low <= ~trig;
            live     <= '0;
            sat      <= 1'b0;
            hold     <= '0;
        end else begin
            trig_q   <= trig;
            seen_low <= seen_low | ~trig;
            if (terminal) begin
                hold <= {sat_nxt, live_nxt};
                live <= '0;
                sat  <= 1'b0;
            end else begin
                live <= live_nxt;
                sat  <= sat_nxt;
            end
        end
    end

endmodule

// File: rtl/beam_trigger_scaler.sv
// Per-beam trigger rate scaler: gate counter, period latch, atomic transfer
// of all beam counts at gate end, and a registered readback port.
module beam_trigger_scaler
    import beam_scaler_pkg::*;
#(
    parameter int NBEAMS       = 2,
    parameter int COUNT_WIDTH  = COUNT_WIDTH_DEF,
    parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEF,
    localparam int ADDR_W      = clog2_min1(NBEAMS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NBEAMS-1:0]       trigger_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    input  logic [ADDR_W-1:0]       rd_addr_i,
    output logic [COUNT_WIDTH:0]    rd_data_o,
    output logic                    scal_valid_o
);

    localparam logic [PERIOD_WIDTH-1:0] P_ONE = 1;

    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] period_eff;
    logic [PERIOD_WIDTH-1:0] gate_cnt;
    logic                    terminal;
    logic [COUNT_WIDTH:0]    hold [NBEAMS];

    assign period_eff = (period_i == '0) ? P_ONE : period_i;
    assign terminal   = (gate_cnt == period_q - P_ONE);

    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
        beam_scaler_counter #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_cnt (
            .clk      (clk_i),
            .rst      (rst_i),
            .trig     (trigger_i[b]),
            .terminal (terminal),
            .hold     (hold[b])
        );
    end

    // New period only ever takes effect at a gate boundary.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_q     <= period_eff;
            gate_cnt     <= '0;
            scal_valid_o <= 1'b0;
        end else begin
            scal_valid_o <= terminal;
            if (terminal) begin
                gate_cnt <= '0;
                period_q <= period_eff;
            end else begin
                gate_cnt <= gate_cnt + P_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
        end else if (32'(rd_addr_i) < NBEAMS) begin
            rd_data_o <= hold[rd_addr_i];
        end else begin
            rd_data_o <= '0;
        end
    end

endmodule

// File: tb/tb_beam_trigger_scaler.sv
// Directed bench for beam_trigger_scaler with an expected-value queue
// popped on each readback.
module tb_beam_trigger_scaler;

    localparam int NB = 3;
    localparam int CW = 4;
    localparam int PW = 32;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] trig = '0;
    logic [PW-1:0] period = 32'd100;
    logic [AW-1:0] addr = '0;
    logic [CW:0]   rdata;
    logic          valid;

    int total  = 0;
    int bad    = 0;
    int cyc    = 0;
    int gstart = 0;
    int lows   = 0;

    logic [CW:0] exp_q [$];

    beam_trigger_scaler #(
        .NBEAMS       (NB),
        .COUNT_WIDTH  (CW),
        .PERIOD_WIDTH (PW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .trigger_i    (trig),
        .period_i     (period),
        .rd_addr_i    (addr),
        .rd_data_o    (rdata),
        .scal_valid_o (valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [NB-1:0] m, input int n,
                         input logic [NB-1:0] base);
        repeat (n) begin
            trig = m | base;
            tick();
            trig = base;
            tick();
        end
    endtask

    task automatic rd(input string tag, input int a);
        logic [CW:0] e;
        addr = AW'(a);
        tick();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check(tag, 32'(rdata), 32'(e));
    endtask

    task automatic wait_valid(input string tag, input int gap);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid && n < 300);
        check(tag, valid ? 32'(cyc - gstart) : 32'hFFFF_FFFF, 32'(gap));
        gstart = cyc;
    endtask

    task automatic until_cyc(input int n);
        while (cyc < gstart + n) tick();
    endtask

    initial begin
        repeat (3) tick();
        check("rst_valid", 32'(valid), 0);
        check("rst_rdata", 32'(rdata), 0);
        rst = 1'b0;
        gstart = cyc;

        // gate 0: 7 pulses on beam 0, 3 on beam 1
        pulse(3'b011, 3, 3'b000);
        pulse(3'b001, 4, 3'b000);
        exp_q.push_back(5'd7);
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd0);
        wait_valid("g0_gap", 100);
        rd("g0_b0", 0);
        rd("g0_b1", 1);
        rd("g0_b2", 2);
        check("g0_single_pulse", 32'(valid), 0);

        // gate 1: beam 0 held 50 cycles, beam 1 saturates with 20 pulses
        pulse(3'b010, 20, 3'b001);
        trig = 3'b001;
        repeat (10) tick();
        trig = 3'b000;
        tick();
        exp_q.push_back(5'd1);
        exp_q.push_back(5'h1F);
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd0);
        wait_valid("g1_gap", 100);
        rd("g1_held", 0);
        rd("g1_sat", 1);
        rd("g1_b2", 2);
        rd("g1_oor", 3);

        // gate 2: 2 pulses, plus one in the terminal cycle
        pulse(3'b010, 2, 3'b000);
        until_cyc(99);
        trig = 3'b010;
        addr = 2'd1;
        tick();
        check("term_valid", 32'(valid), 1);
        check("term_gap", 32'(cyc - gstart), 100);
        check("term_rd_old", 32'(rdata), 32'h1F);
        gstart = cyc;
        trig = 3'b001;
        tick();
        trig = 3'b000;
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd0);
        rd("g2_b0", 0);
        rd("g2_b1", 1);
        rd("g2_b2", 2);

        // gate 3: period change mid-gate
        period = 32'd10;
        exp_q.push_back(5'd1);
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd0);
        wait_valid("g3_gap", 100);
        rd("g3_b0", 0);
        rd("g3_b1", 1);
        rd("g3_b2", 2);
        wait_valid("p10_gap_a", 10);
        wait_valid("p10_gap_b", 10);

        // period 0 behaves as 1
        period = 32'd0;
        wait_valid("p0_gap", 10);
        repeat (20) begin
            tick();
            if (!valid) lows++;
        end
        check("p0_continuous", 32'(lows), 0);

        // reset mid-gate discards partial counts
        period = 32'd100;
        rst = 1'b1;
        tick();
        tick();
        check("rst2_valid", 32'(valid), 0);
        check("rst2_rdata", 32'(rdata), 0);
        rst = 1'b0;
        gstart = cyc;
        pulse(3'b001, 5, 3'b000);
        rst = 1'b1;
        trig = 3'b100;
        repeat (3) tick();
        check("rst_mid_valid", 32'(valid), 0);
        rst = 1'b0;
        gstart = cyc;
        repeat (6) tick();
        trig = 3'b000;
        pulse(3'b001, 2, 3'b000);
        exp_q.push_back(5'd2);
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd0);
        wait_valid("rst_gap", 100);
        rd("rst_b0", 0);
        rd("rst_b1", 1);
        rd("rst_held_b2", 2);
        rd("rst_oor", 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
